// File: rtl/read_combiner.sv
// read_combiner: collapses back-to-back s0 reads of one line into a single m0 read and replays the line in order.
// Define READ_COMBINER_HIT_COUNT_EN to enable the saturating combined-read counter on hit_count.
module read_combiner #(
   parameter int AVM_WIDTH        = 512,
   parameter int AVM_ADDR_WIDTH   = 64,
   parameter int AVM_BYTEEN_WIDTH = 64,
   parameter int MAX_PENDING      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        s0_waitrequest,
   output logic [AVM_WIDTH-1:0]        s0_readdata,
   output logic                        s0_readdatavalid,
   input  logic [AVM_WIDTH-1:0]        s0_writedata,
   input  logic [AVM_ADDR_WIDTH-1:0]   s0_address,
   input  logic                        s0_write,
   input  logic                        s0_read,
   input  logic [AVM_BYTEEN_WIDTH-1:0] s0_byteenable,
   input  logic                        m0_waitrequest,
   input  logic [AVM_WIDTH-1:0]        m0_readdata,
   input  logic                        m0_readdatavalid,
   output logic [AVM_WIDTH-1:0]        m0_writedata,
   output logic [AVM_ADDR_WIDTH-1:0]   m0_address,
   output logic                        m0_write,
   output logic                        m0_read,
   output logic [AVM_BYTEEN_WIDTH-1:0] m0_byteenable,
   output logic [31:0]                 hit_count
);
   localparam int OFF = $clog2(AVM_BYTEEN_WIDTH);
   localparam int PW  = $clog2(MAX_PENDING);
   localparam int LW  = AVM_ADDR_WIDTH - OFF;
   logic [LW-1:0]               last_line_q, last_line_d;
   logic [AVM_BYTEEN_WIDTH-1:0] last_be_q, last_be_d;
   logic                        last_valid_q, last_valid_d;
   logic                        tag_mem_q [MAX_PENDING];
   logic [AVM_WIDTH-1:0]        data_mem_q [MAX_PENDING];
   logic [PW-1:0]               tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d, data_wr_q, data_wr_d, data_rd_q, data_rd_d;
   logic [PW:0]                 tag_cnt_q, tag_cnt_d, data_cnt_q, data_cnt_d, out_cnt_q, out_cnt_d;
   logic [AVM_WIDTH-1:0]        last_data_q, last_data_d, rdata_q, rdata_d;
   logic                        rvalid_q, rvalid_d;
   logic hit, tag_full, acc_hit, acc_miss, acc_wr, tag_push, tag_pop, data_push, data_pop, head_reuse;
   assign hit            = s0_read && last_valid_q && s0_address[AVM_ADDR_WIDTH-1:OFF] == last_line_q
                           && s0_byteenable == last_be_q;
   assign tag_full       = tag_cnt_q == (PW+1)'(MAX_PENDING);
   assign m0_read        = !reset && s0_read && !hit && !tag_full;
   assign m0_write       = !reset && s0_write && !tag_full;
   assign s0_waitrequest = reset || tag_full || (!hit && m0_waitrequest);
   assign m0_writedata   = s0_writedata;
   assign m0_address     = s0_address;
   assign m0_byteenable  = s0_byteenable;
   assign acc_hit        = !reset && hit && !tag_full;
   assign acc_miss       = m0_read && !m0_waitrequest;
   assign acc_wr         = m0_write && !m0_waitrequest;
   assign tag_push       = acc_hit || acc_miss;
   // Tag bit set marks a REUSE entry that replays last_data instead of consuming the data FIFO.
   assign head_reuse     = tag_mem_q[tag_rd_q];
   assign tag_pop        = tag_cnt_q != '0 && (head_reuse || data_cnt_q != '0);
   assign data_pop       = tag_pop && !head_reuse;
   assign data_push      = m0_readdatavalid && out_cnt_q != '0;
   assign s0_readdata      = rdata_q;
   assign s0_readdatavalid = rvalid_q;
   always_comb begin
      last_line_d  = acc_miss ? s0_address[AVM_ADDR_WIDTH-1:OFF] : last_line_q;
      last_be_d    = acc_miss ? s0_byteenable : last_be_q;
      last_valid_d = acc_wr ? 1'b0 : acc_miss ? 1'b1 : last_valid_q;
      tag_wr_d     = tag_wr_q + PW'(tag_push);
      tag_rd_d     = tag_rd_q + PW'(tag_pop);
      data_wr_d    = data_wr_q + PW'(data_push);
      data_rd_d    = data_rd_q + PW'(data_pop);
      tag_cnt_d    = tag_cnt_q + (PW+1)'(tag_push) - (PW+1)'(tag_pop);
      data_cnt_d   = data_cnt_q + (PW+1)'(data_push) - (PW+1)'(data_pop);
      out_cnt_d    = out_cnt_q + (PW+1)'(acc_miss) - (PW+1)'(data_push);
      rvalid_d     = tag_pop;
      rdata_d      = !tag_pop ? rdata_q : head_reuse ? last_data_q : data_mem_q[data_rd_q];
      last_data_d  = data_pop ? data_mem_q[data_rd_q] : last_data_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         last_line_q  <= '0;
         last_be_q    <= '0;
         last_valid_q <= 1'b0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         data_wr_q    <= '0;
         data_rd_q    <= '0;
         tag_cnt_q    <= '0;
         data_cnt_q   <= '0;
         out_cnt_q    <= '0;
         last_data_q  <= '0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         last_line_q  <= last_line_d;
         last_be_q    <= last_be_d;
         last_valid_q <= last_valid_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         data_wr_q    <= data_wr_d;
         data_rd_q    <= data_rd_d;
         tag_cnt_q    <= tag_cnt_d;
         data_cnt_q   <= data_cnt_d;
         out_cnt_q    <= out_cnt_d;
         last_data_q  <= last_data_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
      end
   end
   always_ff @(posedge clk) begin
      if (tag_push) tag_mem_q[tag_wr_q] <= acc_hit;
      if (data_push) data_mem_q[data_wr_q] <= m0_readdata;
   end
`ifdef READ_COMBINER_HIT_COUNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   assign hit_cnt_d = (acc_hit && hit_cnt_q != '1) ? hit_cnt_q + 32'd1 : hit_cnt_q;
   always_ff @(posedge clk) hit_cnt_q <= reset ? '0 : hit_cnt_d;
   assign hit_count = hit_cnt_q;
`else
   assign hit_count = 32'd0;
`endif
endmodule

// File: tb/tb_read_combiner.sv
// tb_read_combiner: directed and randomized checks of read_combiner against a transaction-level model.
module tb_read_combiner;
   localparam int W = 512, AW = 64, BW = 64, MP = 16;
   localparam logic [BW-1:0] ONES = '1;
   logic clk = 1'b0, reset;
   logic s0_waitrequest, s0_readdatavalid, s0_write, s0_read;
   logic m0_waitrequest, m0_readdatavalid, m0_write, m0_read;
   logic [W-1:0] s0_readdata, s0_writedata, m0_readdata, m0_writedata;
   logic [AW-1:0] s0_address, m0_address;
   logic [BW-1:0] s0_byteenable, m0_byteenable;
   logic [31:0] hit_count;
   always #5 clk = ~clk;
   read_combiner dut (
      .clk(clk), .reset(reset),
      .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
      .s0_writedata(s0_writedata), .s0_address(s0_address), .s0_write(s0_write), .s0_read(s0_read),
      .s0_byteenable(s0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid), .m0_writedata(m0_writedata), .m0_address(m0_address),
      .m0_write(m0_write), .m0_read(m0_read), .m0_byteenable(m0_byteenable), .hit_count(hit_count)
   );
   int checks = 0, errors = 0;
   logic [W-1:0] mdata [0:4095];
   int iss_cyc [0:4095];
   int rq [$];
   int iss = 0, ret = 0, arrived = 0, epoch = 0, cyc = 0, hits = 0, lat = 1;
   bit ret_en = 1'b1, last_v = 1'b0, acc;
   logic [AW-7:0] last_line = '0;
   logic [BW-1:0] last_be = '0;

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // rq holds, per accepted s0 read, the index of the m0 read whose line it returns; reads
   // respond in order once that line has arrived, and a combined read shares its issuer's index.
   task automatic cycle(bit rd, bit wr, logic [AW-1:0] a, logic [BW-1:0] be, bit mw, bit rst, output bit accepted);
      bit hit, full, ew, emr, emw, mv, pop;
      int pidx;
      logic [W-1:0] wd;
      pidx = -1;
      wd = rnd();
      s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = wd;
      m0_waitrequest = mw; reset = rst;
      mv = ret_en && ret < iss && cyc >= iss_cyc[ret] + lat;
      m0_readdatavalid = mv;
      m0_readdata = mv ? mdata[ret] : rnd();
      hit = rd && last_v && a[AW-1:6] == last_line && be == last_be;
      full = rq.size() == MP;
      ew = rst || full || (!hit && mw);
      emr = !rst && rd && !hit && !full;
      emw = !rst && wr && !full;
      accepted = !rst && (rd || wr) && !ew;
      pop = !rst && rq.size() > 0 && rq[0] < arrived;
      @(negedge clk);
      if (rd || wr || rst) chk("s0_waitrequest", W'(s0_waitrequest), W'(ew));
      chk("m0_read", W'(m0_read), W'(emr));
      chk("m0_write", W'(m0_write), W'(emw));
      if (rd || wr) chk("m0_address", W'(m0_address), W'(a));
      if (wr) chk("m0_writedata", m0_writedata, wd);
      if (wr) chk("m0_byteenable", W'(m0_byteenable), W'(be));
`ifdef READ_COMBINER_HIT_COUNT_EN
      chk("hit_count", W'(hit_count), W'(hits));
`else
      chk("hit_count", W'(hit_count), '0);
`endif
      @(posedge clk);
      #1;
      if (rst) begin
         rq.delete();
         last_v = 1'b0;
         hits = 0;
         epoch = iss;
         arrived = iss;
      end else begin
         if (pop) pidx = rq.pop_front();
         if (accepted && rd && hit) begin
            rq.push_back(iss - 1);
            hits++;
         end else if (accepted && rd) begin
            mdata[iss] = rnd();
            iss_cyc[iss] = cyc;
            rq.push_back(iss);
            iss++;
            last_line = a[AW-1:6];
            last_be = be;
            last_v = 1'b1;
         end else if (accepted && wr) last_v = 1'b0;
      end
      if (mv) begin
         if (ret >= epoch) arrived = ret + 1;
         ret++;
      end
      cyc++;
      chk("s0_readdatavalid", W'(s0_readdatavalid), W'(pop));
      if (pop) chk("s0_readdata", s0_readdata, mdata[pidx]);
      if (rst) chk("s0_readdata_reset", s0_readdata, '0);
   endtask

   task automatic req(bit rd, bit wr, logic [AW-1:0] a, logic [BW-1:0] be);
      int n;
      n = 0;
      do begin
         cycle(rd, wr, a, be, 1'b0, 1'b0, acc);
         n++;
      end while (!acc && n < 200);
      checks++;
      assert (acc) else begin
         errors++;
         $error("FAIL req_timeout: observed not accepted expected accepted within 200 cycles");
      end
   endtask

   task automatic idle(int n);
      repeat (n) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
   endtask

   initial begin
      lat = 3;
      repeat (2) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
      req(1, 0, 64'h1000, ONES);
      req(1, 0, 64'h1008, ONES);
      req(1, 0, 64'h1030, ONES);
      idle(12);
      req(0, 1, 64'h3000, ONES);
      req(1, 0, 64'h1000, ONES);
      req(0, 1, 64'h1000, ONES);
      req(1, 0, 64'h1000, ONES);
      idle(12);
      req(1, 0, 64'h0, ONES);
      req(1, 0, 64'h40, ONES);
      req(1, 0, 64'h0, ONES);
      idle(12);
      ret_en = 0;
      for (int i = 0; i < MP; i++) req(1, 0, 64'h10000 + 64'(i) * 64, ONES);
      repeat (3) cycle(1, 0, 64'h20000, ONES, 1'b0, 1'b0, acc);
      ret_en = 1;
      lat = 1;
      req(1, 0, 64'h20000, ONES);
      idle(30);
      repeat (5) cycle(1, 0, 64'h6000, ONES, 1'b1, 1'b0, acc);
      req(1, 0, 64'h6000, ONES);
      cycle(1, 0, 64'h6010, ONES, 1'b1, 1'b0, acc);
      idle(12);
      ret_en = 0;
      for (int i = 0; i < 4; i++) req(1, 0, 64'h7000 + 64'(i) * 64, ONES);
      repeat (2) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, acc);
      ret_en = 1;
      idle(10);
      req(1, 0, 64'h8000, ONES);
      idle(10);
      for (int k = 0; k < 600; k++) begin
         int op;
         op = $urandom_range(0, 9);
         ret_en = $urandom_range(0, 3) != 0;
         lat = $urandom_range(1, 4);
         cycle(op < 6, op == 6 || op == 7, 64'h4000 + 64'($urandom_range(0, 2)) * 64 + 64'($urandom_range(0, 63)),
               $urandom_range(0, 4) == 0 ? BW'(64'hFF) : ONES, $urandom_range(0, 3) == 0, 1'b0, acc);
      end
      ret_en = 1;
      lat = 1;
      for (int n = 0; n < 200 && rq.size() > 0; n++) idle(1);
      checks++;
      assert (rq.size() == 0) else begin
         errors++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", rq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
